time_set_controller: RTL and testbench
======================================

TIME_SET_CONTROLLER -- requirements
Module: time_set_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: the number of consecutive clk cycles a synchronized button must be stable before its debounced level changes.
REQ-002 Parameter REPEAT_DELAY, default 64: the number of clk cycles from the first inc/dec pulse to the first auto-repeat pulse.
REQ-003 Parameter REPEAT_PERIOD, default 16: the number of clk cycles between consecutive auto-repeat pulses.
REQ-004 Parameter TIMEOUT_TICKS, default 10: the number of tick pulses without a press before the block returns to RUN.
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 btn_mode  input  1  raw, asynchronous, active-high mode button.
REQ-008 btn_inc  input  1  raw, asynchronous, active-high increment button.
REQ-009 btn_dec  input  1  raw, asynchronous, active-high decrement button.
REQ-010 tick  input  1  single-cycle 1 Hz strobe, synchronous to clk.
REQ-011 set_hour  output  1  hour counter is in manual-set mode.
REQ-012 set_min  output  1  minute counter is in manual-set mode.
REQ-013 set_sec  output  1  second counter is in manual-set mode.
REQ-014 up  output  1  single-cycle increment pulse to the selected counter.
REQ-015 down  output  1  single-cycle decrement pulse to the selected counter.
REQ-016 mode  output  2  current state encoding: 0=RUN, 1=SET_HOUR, 2=SET_MIN, 3=SET_SEC.

Function
REQ-017 Each raw button SHALL pass through a 2-flop synchronizer followed by a debouncer; the debounced level SHALL change only after DEBOUNCE_CYCLES consecutive cycles of a differing synchronized value.
REQ-018 A press event SHALL be a single-cycle pulse on the debounced rising edge, asserted exactly DEBOUNCE_CYCLES+3 clk edges after the raw input rises and stays high; a release SHALL produce no event.
REQ-019 The FSM SHALL advance on each mode press: RUN->SET_HOUR->SET_MIN->SET_SEC->RUN.
REQ-020 set_hour, set_min and set_sec SHALL be one-hot while in the matching SET state and all low in RUN; they SHALL be registered and SHALL change on the same edge as mode.
REQ-021 In a SET state, an inc press SHALL drive up high for exactly one cycle, the cycle after the press event; a dec press SHALL do the same on down.
REQ-022 In RUN, up and down SHALL remain low regardless of inc/dec activity.
REQ-023 up and down SHALL never be high in the same cycle; if inc and dec press events coincide, both SHALL be dropped.
REQ-024 If a mode press event coincides with an inc/dec event or a repeat pulse, the mode press SHALL win and the inc/dec event or repeat pulse SHALL be dropped.
REQ-025 In a SET state, a timeout counter SHALL count tick pulses.
REQ-026 The timeout counter SHALL clear on any press event, repeat pulse or state change.
REQ-027 When the timeout counter reaches TIMEOUT_TICKS, the FSM SHALL return to RUN on that edge.
REQ-028 The timeout counter SHALL be held at 0 in RUN.
REQ-029 Counter widths SHALL be ceil(log2(param+1)) bits, and counters SHALL saturate and never wrap.

Reset
REQ-030 While rst_n is low, the block SHALL be in RUN with mode=0, set_* = 0, up = down = 0, synchronizers and debounced levels at 0, and all counters at 0.
REQ-031 Reset asserted mid-operation, including mid-debounce or mid-repeat, SHALL immediately force the full reset state of REQ-030.
REQ-032 A button already held high when rst_n deasserts SHALL generate one press event after debounce.

Configuration
REQ-033 The macro AUTO_REPEAT_EN SHALL control the auto-repeat feature.
REQ-034 With AUTO_REPEAT_EN defined, in a SET state, while the debounced inc (or dec) is held alone, the first repeat pulse SHALL occur REPEAT_DELAY cycles after the initial up (or down) pulse.
REQ-035 With AUTO_REPEAT_EN defined, subsequent repeat pulses SHALL occur every REPEAT_PERIOD cycles.
REQ-036 With AUTO_REPEAT_EN defined, repeat SHALL stop on release, when the other button is also held, or on any state change.
REQ-037 With AUTO_REPEAT_EN undefined, the repeat logic SHALL be absent and each press SHALL yield exactly one pulse.

Verification
REQ-038 The bench SHALL use parameters DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8 and TIMEOUT_TICKS=3.
REQ-039 Scenario: 4 clean mode presses from reset -> mode steps 1,2,3,0; set_hour, set_min, set_sec each asserted in turn; each press pulse occurs 7 edges after the raw rise.
REQ-040 Scenario: btn_inc bouncing with 1-3 cycle glitches, then held 10 cycles in SET_MIN -> exactly one up pulse; down stays 0.
REQ-041 Scenario: with AUTO_REPEAT_EN defined, btn_dec held 60 cycles in SET_SEC after debounce -> down pulses at t0, t0+20, +28, +36, +44, +52; undefined -> a single pulse at t0.
REQ-042 Scenario: btn_inc and btn_dec rising in the same cycle in SET_HOUR -> up=0 and down=0 throughout.
REQ-043 Scenario: SET_HOUR with no presses and 3 tick pulses -> mode=0 and set_hour=0 on the 3rd tick edge; a press between ticks restarts the count.
REQ-044 Scenario: rst_n pulsed low during a repeat burst in SET_MIN -> outputs at reset values immediately; a held btn_inc after release yields no up pulse while in RUN.

Source files
------------

// File: rtl/time_set_controller.sv
// time_set_controller: synchronizes and debounces the mode/inc/dec buttons and steps RUN -> SET_HOUR -> SET_MIN -> SET_SEC.
// Define AUTO_REPEAT_EN to build the held-button auto-repeat of up/down pulses.
module time_set_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_PERIOD   = 16,
  parameter int unsigned TIMEOUT_TICKS   = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       tick,
  output logic       set_hour,
  output logic       set_min,
  output logic       set_sec,
  output logic       up,
  output logic       down,
  output logic [1:0] mode
);

  localparam int unsigned NB     = 3;
  localparam int unsigned B_MODE = 0;
  localparam int unsigned B_INC  = 1;
  localparam int unsigned B_DEC  = 2;
  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_TICKS + 1);

  // Zero-length timers would never fire.
  if (DEBOUNCE_CYCLES == 0 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0 || TIMEOUT_TICKS == 0) begin : g_param_check
    $error("time_set_controller: timing parameters must be nonzero");
  end

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_SET_HOUR = 2'd1,
    S_SET_MIN  = 2'd2,
    S_SET_SEC  = 2'd3
  } state_t;

  logic [NB-1:0]            w_btn_raw;
  logic [NB-1:0]            r_sync1, r_sync2, r_db, r_db_d, r_press;
  logic [NB-1:0][DB_W-1:0]  r_db_cnt;

  state_t                   r_state, w_state_nxt;
  logic                     r_up, r_down, r_set_hour, r_set_min, r_set_sec;
  logic                     w_up_nxt, w_down_nxt;
  logic [TO_W-1:0]          r_to_cnt, w_to_nxt;
  logic                     w_set, w_rep, w_rep_dec;
  logic                     w_inc_ev, w_dec_ev, w_any_ev;

  assign w_btn_raw = {btn_dec, btn_inc, btn_mode};

  // Press pulse is registered off the debounced edge: raw rise + 2 sync + DEBOUNCE_CYCLES + 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_db     <= '0;
      r_db_d   <= '0;
      r_press  <= '0;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      r_db_d  <= r_db;
      r_press <= r_db & ~r_db_d;
      for (int unsigned i = 0; i < NB; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          r_db[i]     <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign w_set    = (r_state != S_RUN);
  assign w_inc_ev = w_set && !r_press[B_MODE] && (r_press[B_INC] || (w_rep && !w_rep_dec));
  assign w_dec_ev = w_set && !r_press[B_MODE] && (r_press[B_DEC] || (w_rep && w_rep_dec));
  assign w_any_ev = (|r_press) || w_rep;

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RP_W   = $clog2(RP_MAX + 1);

  logic            r_rep_act, r_rep_dir_dec, r_rep_periodic;
  logic [RP_W-1:0] r_rep_cnt;
  logic            w_hold;

  // Repeat only continues while its own button is the sole one held.
  assign w_hold    = r_rep_dir_dec ? (w_set && r_db[B_DEC] && !r_db[B_INC])
                                   : (w_set && r_db[B_INC] && !r_db[B_DEC]);
  assign w_rep     = r_rep_act && w_hold && !r_press[B_MODE] &&
                     (r_rep_cnt == (r_rep_periodic ? RP_W'(REPEAT_PERIOD) : RP_W'(REPEAT_DELAY)));
  assign w_rep_dec = r_rep_dir_dec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep_act      <= 1'b0;
      r_rep_dir_dec  <= 1'b0;
      r_rep_periodic <= 1'b0;
      r_rep_cnt      <= '0;
    end else if (w_state_nxt != r_state || r_press[B_MODE]) begin
      r_rep_act <= 1'b0;
      r_rep_cnt <= '0;
    end else if (w_set && r_press[B_INC] && !r_press[B_DEC]) begin
      r_rep_act      <= 1'b1;
      r_rep_dir_dec  <= 1'b0;
      r_rep_periodic <= 1'b0;
      r_rep_cnt      <= RP_W'(1);
    end else if (w_set && r_press[B_DEC] && !r_press[B_INC]) begin
      r_rep_act      <= 1'b1;
      r_rep_dir_dec  <= 1'b1;
      r_rep_periodic <= 1'b0;
      r_rep_cnt      <= RP_W'(1);
    end else if (r_rep_act) begin
      if (!w_hold) begin
        r_rep_act <= 1'b0;
        r_rep_cnt <= '0;
      end else if (w_rep) begin
        r_rep_periodic <= 1'b1;
        r_rep_cnt      <= RP_W'(1);
      end else if (r_rep_cnt != '1) begin
        r_rep_cnt <= r_rep_cnt + RP_W'(1);
      end
    end
  end
`else
  assign w_rep     = 1'b0;
  assign w_rep_dec = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_to_nxt    = r_to_cnt;
    w_up_nxt    = w_inc_ev && !w_dec_ev;
    w_down_nxt  = w_dec_ev && !w_inc_ev;

    if (r_press[B_MODE]) begin
      unique case (r_state)
        S_RUN:      w_state_nxt = S_SET_HOUR;
        S_SET_HOUR: w_state_nxt = S_SET_MIN;
        S_SET_MIN:  w_state_nxt = S_SET_SEC;
        S_SET_SEC:  w_state_nxt = S_RUN;
      endcase
    end else if (w_set && !w_any_ev && tick && (r_to_cnt >= TO_W'(TIMEOUT_TICKS - 1))) begin
      w_state_nxt = S_RUN;
    end

    if (!w_set || w_any_ev || (w_state_nxt != r_state)) begin
      w_to_nxt = '0;
    end else if (tick && (r_to_cnt != TO_W'(TIMEOUT_TICKS))) begin
      w_to_nxt = r_to_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_RUN;
      r_to_cnt   <= '0;
      r_up       <= 1'b0;
      r_down     <= 1'b0;
      r_set_hour <= 1'b0;
      r_set_min  <= 1'b0;
      r_set_sec  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_to_cnt   <= w_to_nxt;
      r_up       <= w_up_nxt;
      r_down     <= w_down_nxt;
      r_set_hour <= (w_state_nxt == S_SET_HOUR);
      r_set_min  <= (w_state_nxt == S_SET_MIN);
      r_set_sec  <= (w_state_nxt == S_SET_SEC);
    end
  end

  assign mode     = r_state;
  assign set_hour = r_set_hour;
  assign set_min  = r_set_min;
  assign set_sec  = r_set_sec;
  assign up       = r_up;
  assign down     = r_down;

endmodule

// File: tb/tb_time_set_controller.sv
// Bench for time_set_controller: directed scenarios plus random buttons/ticks against a history-based reference model.
module tb_time_set_controller;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;
  localparam int TO = 3;
`ifdef AUTO_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, tick = 1'b0;
  logic       set_hour, set_min, set_sec, up, down;
  logic [1:0] mode;

  int total = 0;
  int bad   = 0;

  time_set_controller #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .TIMEOUT_TICKS  (TO)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_mode(btn_mode),
    .btn_inc (btn_inc),
    .btn_dec (btn_dec),
    .tick    (tick),
    .set_hour(set_hour),
    .set_min (set_min),
    .set_sec (set_sec),
    .up      (up),
    .down    (down),
    .mode    (mode)
  );

  always #5 clk = ~clk;

  // reference model state: values visible in the current cycle
  logic [2:0] hist[$];
  int         cyc;
  int         m_mode, m_to, m_rep_at;
  bit         m_up, m_dn, m_rep_on, m_rep_dir;
  bit [2:0]   m_db, m_rose, m_press;

  int stp = 0;
  int up_n = 0, dn_n = 0;
  int dn_times[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    cyc = 0; m_mode = 0; m_to = 0; m_rep_at = 0;
    m_up = 0; m_dn = 0; m_rep_on = 0; m_rep_dir = 0;
    m_db = '0; m_rose = '0; m_press = '0;
  endtask

  function automatic bit raw_at(input int b, input int k);
    logic [2:0] v;
    if (k < 1 || k > hist.size()) return 1'b0;
    v = hist[k-1];
    return v[b];
  endfunction

  task automatic model_edge();
    bit pm, pi, pd, set, hold_i, hold_d, hold, rep, iev, dev, anyev, flip;
    int nmode, nto;
    bit [2:0] ndb, nrose;
    cyc++;
    hist.push_back({btn_dec, btn_inc, btn_mode});
    pm = m_press[0]; pi = m_press[1]; pd = m_press[2];
    set    = (m_mode != 0);
    hold_i = set && m_db[1] && !m_db[2];
    hold_d = set && m_db[2] && !m_db[1];
    hold   = m_rep_dir ? hold_d : hold_i;
    rep    = REP_ON && m_rep_on && hold && !pm && (cyc == m_rep_at);
    iev    = set && !pm && (pi || (rep && !m_rep_dir));
    dev    = set && !pm && (pd || (rep && m_rep_dir));
    anyev  = pm || pi || pd || rep;
    if (pm) nmode = (m_mode + 1) % 4;
    else if (set && !anyev && tick && (m_to + 1 >= TO)) nmode = 0;
    else nmode = m_mode;
    if (!set || anyev || nmode != m_mode) nto = 0;
    else if (tick) nto = (m_to + 1 > TO) ? TO : m_to + 1;
    else nto = m_to;
    if (nmode != m_mode || pm) m_rep_on = 0;
    else if (set && pi && !pd) begin m_rep_on = 1; m_rep_dir = 0; m_rep_at = cyc + RD; end
    else if (set && pd && !pi) begin m_rep_on = 1; m_rep_dir = 1; m_rep_at = cyc + RD; end
    else if (m_rep_on) begin
      if (!hold) m_rep_on = 0;
      else if (rep) m_rep_at = cyc + RP;
    end
    // debounced level flips when the last DB synchronized samples all differ from it
    for (int b = 0; b < 3; b++) begin
      flip = 1;
      for (int m = cyc - DB + 1; m <= cyc; m++)
        if (raw_at(b, m - 2) == m_db[b]) flip = 0;
      ndb[b]   = flip ? !m_db[b] : m_db[b];
      nrose[b] = flip && !m_db[b];
    end
    m_press = m_rose; m_rose = nrose; m_db = ndb;
    m_mode = nmode; m_to = nto;
    m_up = iev && !dev; m_dn = dev && !iev;
  endtask

  task automatic check_outputs();
    chk("mode", mode, m_mode);
    chk("set_hour", set_hour, m_mode == 1);
    chk("set_min", set_min, m_mode == 2);
    chk("set_sec", set_sec, m_mode == 3);
    chk("up", up, m_up);
    chk("down", down, m_dn);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_outputs();
    stp++;
    if (up === 1'b1) up_n++;
    if (down === 1'b1) begin dn_n++; dn_times.push_back(stp); end
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; repeat (12) step();
    btn_mode = 1'b0; repeat (10) step();
  endtask

  task automatic tick_gap();
    tick = 1'b1; step(); tick = 1'b0; repeat (4) step();
  endtask

  int offs[6] = '{0, 20, 28, 36, 44, 52};
  int s0, n_exp;

  initial begin
    // reset state
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    check_outputs();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();

    // four mode presses: mode changes on the 8th edge after the raw rise
    for (int k = 1; k <= 4; k++) begin
      btn_mode = 1'b1;
      repeat (7) step();
      chk("mode_before_press", mode, (k - 1) % 4);
      step();
      chk("mode_after_press", mode, k % 4);
      chk("set_hour_seq", set_hour, k == 1);
      chk("set_min_seq", set_min, k == 2);
      chk("set_sec_seq", set_sec, k == 3);
      repeat (4) step();
      btn_mode = 1'b0;
      repeat (10) step();
    end

    // bouncing inc in SET_MIN -> one up pulse
    press_mode(); press_mode();
    chk("in_set_min", mode, 2);
    up_n = 0; dn_n = 0;
    for (int g = 0; g < 6; g++) begin
      btn_inc = 1'b1; repeat ($urandom_range(1, 3)) step();
      btn_inc = 1'b0; repeat ($urandom_range(1, 3)) step();
    end
    btn_inc = 1'b1; repeat (10) step();
    btn_inc = 1'b0; repeat (12) step();
    chk("bounce_up_count", up_n, 1);
    chk("bounce_down_count", dn_n, 0);

    // dec held in SET_SEC: repeat timing
    press_mode();
    chk("in_set_sec", mode, 3);
    dn_times.delete();
    s0 = stp;
    btn_dec = 1'b1; repeat (60) step();
    btn_dec = 1'b0; repeat (30) step();
    n_exp = REP_ON ? 6 : 1;
    chk("repeat_count", dn_times.size(), n_exp);
    if (dn_times.size() > 0) begin
      chk("first_down_latency", dn_times[0] - s0, 8);
      for (int i = 1; i < n_exp && i < dn_times.size(); i++)
        chk("repeat_offset", dn_times[i] - dn_times[0], offs[i]);
    end

    // simultaneous inc/dec in SET_HOUR
    press_mode(); press_mode();
    chk("in_set_hour", mode, 1);
    up_n = 0; dn_n = 0;
    btn_inc = 1'b1; btn_dec = 1'b1; repeat (40) step();
    btn_inc = 1'b0; btn_dec = 1'b0; repeat (12) step();
    chk("both_up_count", up_n, 0);
    chk("both_down_count", dn_n, 0);

    // timeout after three ticks
    tick_gap(); chk("to_tick1", mode, 1);
    tick_gap(); chk("to_tick2", mode, 1);
    tick = 1'b1; step(); tick = 1'b0;
    chk("timeout_mode", mode, 0);
    chk("timeout_set_hour", set_hour, 0);
    repeat (4) step();

    // a press between ticks restarts the count
    press_mode();
    tick_gap(); tick_gap();
    btn_inc = 1'b1; repeat (12) step();
    btn_inc = 1'b0; repeat (10) step();
    tick_gap(); tick_gap();
    chk("restart_mode", mode, 1);
    tick = 1'b1; step(); tick = 1'b0;
    chk("restart_timeout_mode", mode, 0);
    repeat (4) step();

    // reset during repeat burst, inc held through release
    press_mode(); press_mode();
    btn_inc = 1'b1; repeat (40) step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("rst_mid_mode", mode, 0);
    chk("rst_mid_up", up, 0);
    repeat (3) step();
    rst_n = 1'b1;
    up_n = 0;
    repeat (30) step();
    chk("post_rst_up_count", up_n, 0);
    chk("post_rst_mode", mode, 0);
    btn_inc = 1'b0; repeat (10) step();

    // random buttons and ticks
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 19) == 0) btn_mode = ~btn_mode;
      if ($urandom_range(0, 11) == 0) btn_inc  = ~btn_inc;
      if ($urandom_range(0, 11) == 0) btn_dec  = ~btn_dec;
      tick = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
